// File: rtl/select_next_hop_pkg.sv
// select_next_hop_pkg: routing-table word width, base addresses and scan FSM states
package select_next_hop_pkg;
    localparam int RT_WORD_WIDTH = 16;
    localparam logic [15:0] KNOWN_SINKS_BASE = 16'h0008;
    localparam logic [15:0] NEIGHBOR_ID_BASE = 16'h0048;
    localparam logic [15:0] CLUSTER_ID_BASE  = 16'h00C8;
    localparam logic [15:0] BATT_STAT_BASE   = 16'h0148;
    localparam logic [15:0] Q_VALUE_BASE     = 16'h01C8;
    localparam logic [15:0] SINK_IDS_BASE    = 16'h0248;
    localparam logic [15:0] SINK_COUNT_ADDR  = 16'h0688;
    localparam logic [15:0] NBR_COUNT_ADDR   = 16'h068A;
    localparam logic [15:0] RESULT_ADDR      = 16'h068C;
    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_ISSUE, S_BATT, S_Q, S_NID, S_WRITE, S_DONE
    } state_e;
    function automatic logic [RT_WORD_WIDTH-1:0] entry_addr(
        input logic [RT_WORD_WIDTH-1:0] base,
        input logic [RT_WORD_WIDTH-1:0] idx
    );
        return base + {idx[RT_WORD_WIDTH-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/select_next_hop.sv
// select_next_hop: scan the neighbour table, pick the eligible neighbour with the lowest qValue, write its ID
module select_next_hop
    import select_next_hop_pkg::*;
#(
    parameter int                    WORD_WIDTH    = RT_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] BATT_MIN      = 'h0010,
    parameter int                    MAX_NEIGHBORS = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] next_hop_id,
    output logic [WORD_WIDTH-1:0] best_q,
    output logic                  found,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = $clog2(MAX_NEIGHBORS + 1);
    localparam logic [WORD_WIDTH-1:0] NONE = '1;
    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d, dout_q, dout_d;
    logic [WORD_WIDTH-1:0] nhid_q, nhid_d, bestq_q, bestq_d;
    logic [WORD_WIDTH-1:0] batt_q, batt_d, qv_q, qv_d;
    logic [IW-1:0]         cnt_q, cnt_d, idx_q, idx_d;
    logic                  wr_q, wr_d, done_q, done_d, found_q, found_d;
    logic [WORD_WIDTH-1:0] idx_w;
    assign idx_w = WORD_WIDTH'(idx_q);
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        nhid_d  = nhid_q;
        bestq_d = bestq_q;
        batt_d  = batt_q;
        qv_d    = qv_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        found_d = found_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = WORD_WIDTH'(NBR_COUNT_ADDR);
                found_d = 1'b0;
                nhid_d  = NONE;
                bestq_d = NONE;
                state_d = S_CNT;
            end
            S_CNT: begin
                cnt_d   = (data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? IW'(MAX_NEIGHBORS) : IW'(data_in);
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                addr_d  = (idx_q == cnt_q) ? addr_q : WORD_WIDTH'(entry_addr(BATT_STAT_BASE, RT_WORD_WIDTH'(idx_w)));
                state_d = (idx_q == cnt_q) ? S_WRITE : S_BATT;
            end
            S_BATT: begin
                batt_d  = data_in;
                addr_d  = WORD_WIDTH'(entry_addr(Q_VALUE_BASE, RT_WORD_WIDTH'(idx_w)));
                state_d = S_Q;
            end
            S_Q: begin
                qv_d    = data_in;
                addr_d  = WORD_WIDTH'(entry_addr(NEIGHBOR_ID_BASE, RT_WORD_WIDTH'(idx_w)));
                state_d = S_NID;
            end
            S_NID: begin
                // strict less-than keeps the lower index on equal qValues
                if (batt_q >= BATT_MIN && (!found_q || qv_q < bestq_q)) begin
                    bestq_d = qv_q;
                    nhid_d  = data_in;
                    found_d = 1'b1;
                end
                idx_d   = idx_q + 1'b1;
                state_d = S_ISSUE;
            end
            S_WRITE: begin
                addr_d  = WORD_WIDTH'(RESULT_ADDR);
                dout_d  = found_q ? nhid_q : NONE;
                wr_d    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            nhid_q  <= NONE;
            bestq_q <= NONE;
            batt_q  <= '0;
            qv_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            nhid_q  <= nhid_d;
            bestq_q <= bestq_d;
            batt_q  <= batt_d;
            qv_q    <= qv_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end
    assign address     = addr_q;
    assign data_out    = dout_q;
    assign wr_en       = wr_q;
    assign next_hop_id = nhid_q;
    assign best_q      = bestq_q;
    assign found       = found_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
endmodule

// File: tb/tb_select_next_hop.sv
// tb_select_next_hop: directed scans against a table memory model, scoreboard checked on each done pulse
module tb_select_next_hop;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_in, address, data_out, next_hop_id, best_q;
    logic        wr_en, found, busy, done;
    logic [15:0] mem [0:2047];
    assign data_in = mem[address[10:0]];
    always #5 clock = ~clock;
    select_next_hop dut (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .address(address), .data_out(data_out), .wr_en(wr_en),
        .next_hop_id(next_hop_id), .best_q(best_q), .found(found),
        .busy(busy), .done(done)
    );
    typedef struct {
        logic [15:0] id;
        logic [15:0] bq;
        logic        f;
        logic [15:0] wd;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    int k = 0, wr_k = 0, wr_cnt = 0, wr_total = 0, done_total = 0;
    logic [15:0] wr_addr, wr_data;
    logic busy_p = 1'b0;
    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction
    // monitor: cycle k=1 is the first busy cycle after the start edge
    always @(negedge clock) begin
        if (busy && !busy_p) begin
            k = 1;
            wr_cnt = 0;
        end else if (k > 0) k++;
        busy_p = busy;
        if (wr_en) begin
            wr_cnt++;
            wr_total++;
            wr_k = k;
            wr_addr = address;
            wr_data = data_out;
        end
        if (done) begin
            done_total++;
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", k, e.lat);
                chk("wr_latency", wr_k, e.lat - 1);
                chk("wr_pulses", wr_cnt, 1);
                chk("wr_addr", wr_addr, 16'h068C);
                chk("wr_data", wr_data, e.wd);
                chk("next_hop_id", next_hop_id, e.id);
                chk("best_q", best_q, e.bq);
                chk("found", found, e.f);
            end
        end
    end
    task automatic load(input int n, input logic [15:0] ids[], input logic [15:0] bt[], input logic [15:0] qs[]);
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        mem[16'h068A] = 16'(n);
        for (int i = 0; i < ids.size(); i++) begin
            mem[16'h0048 + 2*i] = ids[i];
            mem[16'h0148 + 2*i] = bt[i];
            mem[16'h01C8 + 2*i] = qs[i];
        end
    endtask
    task automatic scan(input exp_t e, input int reps);
        for (int r = 0; r < reps; r++) sb.push_back(e);
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < 600 && sb.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        start = 1'b0;
        chk("scan_timeout", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge clock);
    endtask
    function automatic exp_t mk(input logic [15:0] id, input logic [15:0] bq, input logic f, input int lat);
        exp_t e;
        e.id = id; e.bq = bq; e.f = f; e.wd = f ? id : 16'hFFFF; e.lat = lat;
        return e;
    endfunction
    initial begin
        int dc, wc;
        logic [15:0] ids[], bt[], qs[];
        load(0, '{}, '{}, '{});
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_address", address, 16'h0);
        chk("rst_data_out", data_out, 16'h0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_found", found, 0);
        chk("rst_next_hop_id", next_hop_id, 16'hFFFF);
        chk("rst_best_q", best_q, 16'hFFFF);
        scan(mk(16'hFFFF, 16'hFFFF, 0, 5), 1);
        ids = '{16'h11, 16'h22, 16'h33}; bt = '{16'h50, 16'h50, 16'h50}; qs = '{16'd40, 16'd10, 16'd25};
        load(3, ids, bt, qs);
        scan(mk(16'h22, 16'd10, 1, 17), 1);
        chk("hold_next_hop_id", next_hop_id, 16'h22);
        chk("hold_found", found, 1);
        ids = '{16'hA1, 16'hA2}; bt = '{16'h20, 16'h20}; qs = '{16'd5, 16'd5};
        load(2, ids, bt, qs);
        scan(mk(16'hA1, 16'd5, 1, 13), 1);
        ids = '{16'hB1, 16'hB2, 16'hB3}; bt = '{16'h0F, 16'h10, 16'h90}; qs = '{16'd1, 16'd2, 16'd3};
        load(3, ids, bt, qs);
        scan(mk(16'hB2, 16'd2, 1, 17), 1);
        bt = '{16'h0, 16'h0, 16'h0};
        load(3, ids, bt, qs);
        scan(mk(16'hFFFF, 16'hFFFF, 0, 17), 1);
        ids = '{16'h11, 16'h22, 16'h33}; bt = '{16'h50, 16'h50, 16'h50}; qs = '{16'd40, 16'd10, 16'd25};
        load(3, ids, bt, qs);
        dc = done_total;
        wc = wr_total;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_next_hop_id", next_hop_id, 16'hFFFF);
        chk("abort_found", found, 0);
        repeat (30) @(negedge clock);
        chk("abort_no_done", done_total, dc);
        chk("abort_no_write", wr_total, wc);
        scan(mk(16'h22, 16'd10, 1, 17), 1);
        scan(mk(16'h22, 16'd10, 1, 17), 2);
        ids = new[64]; bt = new[64]; qs = new[64];
        for (int i = 0; i < 64; i++) begin
            ids[i] = 16'(16'h100 + i);
            bt[i]  = 16'h20;
            qs[i]  = 16'(1000 - i);
        end
        load(100, ids, bt, qs);
        mem[16'h0248] = 16'h0;
        mem[16'h00C8] = 16'hDEAD;
        scan(mk(16'h013F, 16'd937, 1, 261), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
